// File: rtl/apb_master_initiator.sv
// APB requester: turns one cmd handshake into one APB SETUP+ACCESS transfer and returns a held response.
// Latency: zero-wait slave gives rsp_valid 3 edges after the accept edge; 4-cycle minimum command period.
// Backpressure: cmd_ready only in IDLE; response is held in RESP until rsp_ready, stalling new commands.
module apb_master_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // A TIMEOUT of 0 still needs a legal (unused) 1-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_q,       state_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              pwrite_q,      pwrite_d;
    logic [ADDR_W-1:0] paddr_q,       paddr_d;
    logic [DATA_W-1:0] pwdata_q,      pwdata_d;
    logic              rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic              timeout_hit;

    // Last permitted wait cycle reached; only meaningful while in ACCESS with PREADY low.
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    // Next-state and registered-output computation for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Address/data are frozen here and held until the next accept.
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    // Completion takes priority over a timeout on the same edge.
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else if ((TIMEOUT > 0) && (cnt_q != CNT_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer and pending response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= ST_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_master_initiator.sv
// Bench for apb_master_initiator: transaction-level timing model plus per-cycle compare.
// Each transaction's cycle schedule is derived from its wait count and response delay.
// Directed cases pin the model with literal values, then randomized traffic follows.
module tb_apb_master_initiator;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout, busy;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;

    apb_master_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: APB fields held since last accept, response of current transfer.
    logic          m_pwrite, m_err, m_tmo;
    logic [31:0]   m_paddr, m_pwdata, m_rdata;
    // Expectations for the current cycle.
    logic          e_crdy, e_busy, e_psel, e_pen, e_rv, e_pwrite, e_err, e_tmo;
    logic [31:0]   e_paddr, e_pwdata, e_rdata;
    // Observations of the most recent transaction.
    int            obs_k, obs_pen, obs_lat, obs_rv;
    logic [31:0]   obs_rdata, obs_s_paddr;
    logic          obs_err, obs_tmo, obs_s_psel, obs_s_pen, obs_s_pwrite;

    task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model's expectation for this cycle.
    always @(negedge PCLK) begin
        if (chk_en) begin
            cmp1("cmd_ready", cmd_ready, e_crdy);
            cmp1("busy", busy, e_busy);
            cmp1("PSELx", PSELx, e_psel);
            cmp1("PENABLE", PENABLE, e_pen);
            cmp1("rsp_valid", rsp_valid, e_rv);
            cmp1("PWRITE", PWRITE, e_pwrite);
            cmp32("PADDR", PADDR, e_paddr);
            cmp32("PWDATA", PWDATA, e_pwdata);
            if (e_rv) begin
                cmp32("rsp_rdata", rsp_rdata, e_rdata);
                cmp1("rsp_err", rsp_err, e_err);
                cmp1("rsp_timeout", rsp_timeout, e_tmo);
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic noise();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom();
        cmd_wdata = $urandom();
        PREADY    = 1'($urandom_range(0, 1));
        PSLVERR   = 1'($urandom_range(0, 1));
        PRDATA    = $urandom();
        rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic set_exp(input logic crdy, input logic psel, input logic pen, input logic rv);
        e_crdy   = crdy;
        e_busy   = !crdy;
        e_psel   = psel;
        e_pen    = pen;
        e_rv     = rv;
        e_pwrite = m_pwrite;
        e_paddr  = m_paddr;
        e_pwdata = m_pwdata;
        e_rdata  = m_rdata;
        e_err    = m_err;
        e_tmo    = m_tmo;
    endtask

    task automatic observe();
        if (PENABLE === 1'b1) obs_pen++;
        if (rsp_valid === 1'b1) begin
            if (obs_lat < 0) obs_lat = obs_k;
            obs_rv++;
            obs_rdata = rsp_rdata;
            obs_err   = rsp_err;
            obs_tmo   = rsp_timeout;
        end
        if (obs_k == 1) begin
            obs_s_paddr  = PADDR;
            obs_s_psel   = PSELx;
            obs_s_pen    = PENABLE;
            obs_s_pwrite = PWRITE;
        end
        obs_k++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            noise();
            set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One command: w = PREADY-low ACCESS cycles before completion, d = rsp_ready delay.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int w, input logic serr, input logic [31:0] rd,
                       input int d, input logic early);
        int   n;
        logic tmo;
        obs_k = 0; obs_pen = 0; obs_lat = -1; obs_rv = 0;
        tmo = (w >= TO);
        n   = tmo ? TO : w + 1;
        // accept cycle
        step(); noise();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        observe();
        m_pwrite = wr; m_paddr = addr; m_pwdata = wr ? wd : 32'h0;
        // SETUP
        step(); noise();
        cmd_valid = 1'($urandom_range(0, 1));
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        observe();
        // ACCESS
        for (int i = 0; i < n; i++) begin
            step(); noise();
            cmd_valid = 1'($urandom_range(0, 1));
            PREADY = (i == w);
            if (i == w) begin
                PSLVERR = serr;
                PRDATA  = rd;
            end
            set_exp(1'b0, 1'b1, 1'b1, 1'b0);
            observe();
        end
        m_rdata = tmo ? 32'h0 : (wr ? 32'h0 : rd);
        m_err   = tmo ? 1'b1 : serr;
        m_tmo   = tmo;
        // RESP
        for (int j = 0; j <= d; j++) begin
            step(); noise();
            cmd_valid = early;
            rsp_ready = (j == d);
            set_exp(1'b0, 1'b0, 1'b0, 1'b1);
            observe();
        end
    endtask

    // Reset asserted in the middle of the second ACCESS cycle of a read.
    task automatic reset_mid();
        step(); noise();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_wdata = 32'h55;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        m_pwrite = 1'b0; m_paddr = 32'h44; m_pwdata = 32'h0;
        step(); noise();
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(); noise();
            PREADY = 1'b0;
            set_exp(1'b0, 1'b1, 1'b1, 1'b0);
        end
        #2;
        chk_en  = 1'b0;
        PRESETn = 1'b0;
        #1;
        cmp1("rst_mid_psel", PSELx, 1'b0);
        cmp1("rst_mid_penable", PENABLE, 1'b0);
        cmp1("rst_mid_rsp_valid", rsp_valid, 1'b0);
        cmp1("rst_mid_cmd_ready", cmd_ready, 1'b1);
        cmp32("rst_mid_paddr", PADDR, 32'h0);
        m_pwrite = 1'b0; m_paddr = 32'h0; m_pwdata = 32'h0;
        m_rdata = 32'h0; m_err = 1'b0; m_tmo = 1'b0;
        step(); noise();
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        PRESETn = 1'b1;
        chk_en  = 1'b1;
        idle_cycles(4);
    endtask

    initial begin
        int w;
        PRESETn = 1'b0;
        noise();
        m_pwrite = 1'b0; m_paddr = 32'h0; m_pwdata = 32'h0;
        m_rdata = 32'h0; m_err = 1'b0; m_tmo = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        #12;
        cmp1("reset_psel", PSELx, 1'b0);
        cmp1("reset_penable", PENABLE, 1'b0);
        cmp1("reset_pwrite", PWRITE, 1'b0);
        cmp32("reset_paddr", PADDR, 32'h0);
        cmp32("reset_pwdata", PWDATA, 32'h0);
        cmp1("reset_rsp_valid", rsp_valid, 1'b0);
        cmp32("reset_rsp_rdata", rsp_rdata, 32'h0);
        cmp1("reset_rsp_err", rsp_err, 1'b0);
        cmp1("reset_rsp_timeout", rsp_timeout, 1'b0);
        cmp1("reset_cmd_ready", cmd_ready, 1'b1);
        cmp1("reset_busy", busy, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        chk_en  = 1'b1;
        idle_cycles(2);

        // zero-wait write
        txn(1'b1, 32'h8, 32'h2A5, 0, 1'b0, 32'h1111_1111, 0, 1'b0);
        cmp32("t1_latency", obs_lat, 32'd3);
        cmp32("t1_penable_cycles", obs_pen, 32'd1);
        cmp32("t1_setup_paddr", obs_s_paddr, 32'h8);
        cmp1("t1_setup_psel", obs_s_psel, 1'b1);
        cmp1("t1_setup_penable", obs_s_pen, 1'b0);
        cmp1("t1_setup_pwrite", obs_s_pwrite, 1'b1);
        cmp32("t1_rdata", obs_rdata, 32'h0);
        cmp1("t1_err", obs_err, 1'b0);

        // read with three wait states
        txn(1'b0, 32'h4, 32'h7777_7777, 3, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
        cmp32("t2_penable_cycles", obs_pen, 32'd4);
        cmp32("t2_latency", obs_lat, 32'd6);
        cmp32("t2_rdata", obs_rdata, 32'hDEAD_BEEF);
        cmp1("t2_err", obs_err, 1'b0);

        // slave error on write, next command pending during RESP
        txn(1'b1, 32'h0, 32'hCAFE, 0, 1'b1, 32'h0BAD_0BAD, 2, 1'b1);
        cmp1("t3_err", obs_err, 1'b1);
        cmp1("t3_timeout", obs_tmo, 1'b0);

        // PREADY never rises: timeout after TO ACCESS cycles
        txn(1'b0, 32'h10, 32'h0, 20, 1'b0, 32'h1234_5678, 0, 1'b0);
        cmp32("t4_penable_cycles", obs_pen, 32'd8);
        cmp32("t4_latency", obs_lat, 32'd10);
        cmp1("t4_err", obs_err, 1'b1);
        cmp1("t4_timeout", obs_tmo, 1'b1);
        cmp32("t4_rdata", obs_rdata, 32'h0);

        // PREADY on the last permitted ACCESS cycle: normal completion
        txn(1'b0, 32'h14, 32'h0, 7, 1'b0, 32'h1234_5678, 0, 1'b0);
        cmp32("t5_penable_cycles", obs_pen, 32'd8);
        cmp1("t5_timeout", obs_tmo, 1'b0);
        cmp1("t5_err", obs_err, 1'b0);
        cmp32("t5_rdata", obs_rdata, 32'h1234_5678);

        // response held for 5 cycles with a queued command
        txn(1'b0, 32'h20, 32'h0, 1, 1'b0, 32'hA5A5_0F0F, 5, 1'b1);
        cmp32("t6_latency", obs_lat, 32'd4);
        cmp32("t6_rsp_cycles", obs_rv, 32'd6);
        cmp32("t6_rdata", obs_rdata, 32'hA5A5_0F0F);
        txn(1'b1, 32'h24, 32'h600D, 0, 1'b0, 32'h0, 0, 1'b0);
        cmp32("t6b_latency", obs_lat, 32'd3);

        reset_mid();
        txn(1'b1, 32'h30, 32'hBEEF, 0, 1'b0, 32'h0, 0, 1'b0);
        cmp32("t7_latency", obs_lat, 32'd3);
        cmp1("t7_err", obs_err, 1'b0);

        for (int t = 0; t < 60; t++) begin
            w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), w, 1'($urandom_range(0, 1)),
                $urandom(), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end
        idle_cycles(2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
